// File: rtl/diff_patgen_pkg.sv
// Shared types and constants for the differential-output pattern generator.
package diff_patgen_pkg;

  typedef enum logic [1:0] {
    MODE_HIGH   = 2'd0,
    MODE_TOGGLE = 2'd1,
    MODE_PRBS   = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StPreamble,
    StRun
  } state_e;

  localparam logic [7:0] PREAMBLE  = 8'hAA;
  localparam logic [6:0] PRBS_SEED = 7'h7F;

  // PRBS7 step: shift left, feed back bit6 ^ bit5.
  function automatic logic [6:0] prbs7_next(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchronizer followed by a per-bit debouncer for raw board switches.
// A bit's stable value follows its synchronized input only after the input has
// held a new value for DEBOUNCE_CYCLES consecutive cycles.
module sw_debounce #(
  parameter int unsigned WIDTH           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);

  localparam int unsigned   CntW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] meta_q, sync_q, stable_q;
  logic [CntW-1:0]  cnt_q [WIDTH];

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= raw;
      sync_q <= meta_q;
    end
  end

  // Count cycles the synchronized bit differs from the accepted value; any return clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_q[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntMax) begin
          stable_q[i] <= sync_q[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/diff_out_pattern_gen.sv
// Serial test-pattern generator driving a differential output buffer.
// Sends an 0xAA preamble, then a mode-selected pattern (high, toggle, PRBS7, byte counter).
// Optional build macro: DIFF_PATGEN_PRBS_EN includes the PRBS7 LFSR; without it mode 2
// behaves exactly like the toggle mode.
module diff_out_pattern_gen
  import diff_patgen_pkg::*;
#(
  parameter int unsigned CLK_DIV         = 100,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_en,
  input  logic [1:0] sw_mode,
  output logic       tx_data,
  output logic       tx_active
);

  localparam int unsigned     DivW   = $clog2(CLK_DIV);
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  logic [2:0]      db;
  logic            en_db;
  mode_e           mode_db;
  state_e          state_q, state_d;
  logic [DivW-1:0] div_q;
  logic [2:0]      bit_cnt_q;
  logic            tog_q;
  logic [7:0]      byte_q;
  mode_e           mode_q;
  logic            tx_data_q, tx_active_q;
  logic            bit_tick, start, pat_bit;
`ifdef DIFF_PATGEN_PRBS_EN
  logic [6:0]      lfsr_q;
`endif

  sw_debounce #(
    .WIDTH          (3),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sw_debounce (
    .clk   (clk),
    .rst   (rst),
    .raw   ({sw_mode, sw_en}),
    .stable(db)
  );

  assign en_db    = db[0];
  assign mode_db  = mode_e'(db[2:1]);
  assign bit_tick = (div_q == DivMax);
  // Covers both IDLE->PREAMBLE and the mode-change restart RUN->PREAMBLE.
  assign start    = (state_d == StPreamble) && (state_q != StPreamble);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next-state: enable drop aborts from any state without finishing the bit.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (en_db) state_d = StPreamble;
      StPreamble: begin
        if (!en_db)                             state_d = StIdle;
        else if (bit_tick && bit_cnt_q == 3'd7) state_d = StRun;
      end
      StRun: begin
        if (!en_db)                  state_d = StIdle;
        else if (mode_db != mode_q)  state_d = StPreamble;
      end
      default:    state_d = StIdle;
    endcase
  end

  // Bit timing and pattern state; pattern only advances on bit_tick while in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q     <= '0;
      bit_cnt_q <= '0;
      tog_q     <= 1'b0;
      byte_q    <= '0;
      mode_q    <= MODE_HIGH;
`ifdef DIFF_PATGEN_PRBS_EN
      lfsr_q    <= PRBS_SEED;
`endif
    end else if (start) begin
      div_q     <= '0;
      bit_cnt_q <= '0;
      tog_q     <= 1'b1;
      byte_q    <= '0;
      mode_q    <= mode_db;
`ifdef DIFF_PATGEN_PRBS_EN
      lfsr_q    <= PRBS_SEED;
`endif
    end else if (state_q != StIdle) begin
      div_q <= bit_tick ? '0 : div_q + DivW'(1);
      if (bit_tick) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (state_q == StRun) begin
          tog_q <= ~tog_q;
          if (bit_cnt_q == 3'd7) byte_q <= byte_q + 8'd1;
`ifdef DIFF_PATGEN_PRBS_EN
          lfsr_q <= prbs7_next(lfsr_q);
`endif
        end
      end
    end
  end

  // Select the bit to register onto tx_data; MSB first where bytes are serialized.
  always_comb begin
    pat_bit = 1'b0;
    unique case (state_q)
      StPreamble: pat_bit = PREAMBLE[~bit_cnt_q];
      StRun: begin
        unique case (mode_q)
          MODE_HIGH:   pat_bit = 1'b1;
          MODE_TOGGLE: pat_bit = tog_q;
`ifdef DIFF_PATGEN_PRBS_EN
          MODE_PRBS:   pat_bit = lfsr_q[6];
`else
          MODE_PRBS:   pat_bit = tog_q;
`endif
          MODE_COUNT:  pat_bit = byte_q[~bit_cnt_q];
          default:     pat_bit = 1'b0;
        endcase
      end
      default:    pat_bit = 1'b0;
    endcase
  end

  // Registered outputs, one cycle behind the FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_q   <= 1'b0;
      tx_active_q <= 1'b0;
    end else begin
      tx_data_q   <= pat_bit;
      tx_active_q <= (state_q != StIdle);
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_active = tx_active_q;

endmodule

// File: tb/tb_diff_out_pattern_gen.sv
// Self-checking bench for diff_out_pattern_gen with CLK_DIV=4, DEBOUNCE_CYCLES=8.
module tb_diff_out_pattern_gen;

  localparam int unsigned ClkDiv = 4;
  localparam int unsigned DebCyc = 8;
  // Edges from driving a switch to the first registered output bit:
  // 2 sync + 8 debounce + 1 FSM + 1 output register.
  localparam int Latency = 12;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw_en = 1'b0;
  logic [1:0] sw_mode = 2'd0;
  logic       tx_data, tx_active;

  int n_checks = 0;
  int n_errors = 0;
  bit exp_q[$];

  always #5 clk = ~clk;

  diff_out_pattern_gen #(
    .CLK_DIV        (ClkDiv),
    .DEBOUNCE_CYCLES(DebCyc)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_en    (sw_en),
    .sw_mode  (sw_mode),
    .tx_data  (tx_data),
    .tx_active(tx_active)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_preamble();
    logic [7:0] p;
    p = 8'hAA;
    for (int i = 7; i >= 0; i--) exp_q.push_back(p[i]);
  endtask

  // Independent reference of the RUN patterns.
  task automatic push_run(input int mode, input int nbits);
    logic [6:0] l;
    logic       t;
    logic [7:0] b;
    l = 7'h7F;
    t = 1'b1;
    b = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      case (mode)
        0: exp_q.push_back(1'b1);
        1: exp_q.push_back(t);
`ifdef DIFF_PATGEN_PRBS_EN
        2: exp_q.push_back(l[6]);
`else
        2: exp_q.push_back(t);
`endif
        default: exp_q.push_back(b[7 - (i % 8)]);
      endcase
      t = ~t;
      l = {l[5:0], l[6] ^ l[5]};
      if (i % 8 == 7) b = b + 8'd1;
    end
  endtask

  // Pop expected bits; each must hold for ClkDiv cycles with tx_active high.
  task automatic run_bits(input string tag, input int nbits);
    bit e;
    for (int b = 0; b < nbits; b++) begin
      e = exp_q.pop_front();
      check_eq({tag, "_active"}, tx_active, 1'b1);
      for (int c = 0; c < ClkDiv; c++) begin
        check_eq(tag, tx_data, e);
        tick();
      end
    end
  endtask

  task automatic wait_active(input string tag, input int exp_n);
    int n;
    n = 0;
    while (!tx_active && n < 40) begin
      tick();
      n++;
    end
    check_eq(tag, n, exp_n);
  endtask

  task automatic do_reset(input logic [1:0] mode);
    rst     = 1'b1;
    sw_en   = 1'b0;
    sw_mode = mode;
    tick();
    check_eq("rst_data", tx_data, 1'b0);
    check_eq("rst_active", tx_active, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      check_eq("idle_active", tx_active, 1'b0);
    end
  endtask

  initial begin
    // Mode 1: preamble then toggling.
    do_reset(2'd1);
    sw_en = 1'b1;
    wait_active("m1_latency", Latency);
    push_preamble();
    push_run(1, 16);
    run_bits("m1_bits", 24);

    // Mode 2: PRBS7 (or toggle when the LFSR is not built), past one full period.
    do_reset(2'd2);
    sw_en = 1'b1;
    wait_active("m2_latency", Latency);
    push_preamble();
    push_run(2, 140);
    run_bits("m2_bits", 148);

    // Mode 3: byte counter through the 255->0 wrap.
    do_reset(2'd3);
    sw_en = 1'b1;
    wait_active("m3_latency", Latency);
    push_preamble();
    push_run(3, 257 * 8);
    run_bits("m3_bits", 8 + 257 * 8);

    // Short enable glitch in IDLE must be filtered.
    do_reset(2'd0);
    sw_en = 1'b1;
    repeat (5) tick();
    sw_en = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      check_eq("glitch_active", tx_active, 1'b0);
      check_eq("glitch_data", tx_data, 1'b0);
    end

    // Mode change 1->0 in RUN restarts the preamble, then holds high; then enable drop.
    do_reset(2'd1);
    sw_en = 1'b1;
    wait_active("mc_latency", Latency);
    push_preamble();
    push_run(1, 8);
    run_bits("mc_before", 16);
    sw_mode = 2'd0;
    for (int i = 0; i < Latency; i++) begin
      tick();
      check_eq("mc_active", tx_active, 1'b1);
    end
    push_preamble();
    push_run(0, 8);
    run_bits("mc_after", 16);
    sw_en = 1'b0;
    for (int i = 0; i < Latency - 1; i++) tick();
    check_eq("drop_still_active", tx_active, 1'b1);
    tick();
    check_eq("drop_active", tx_active, 1'b0);
    check_eq("drop_data", tx_data, 1'b0);

    // Reset pulse mid-RUN, then a full re-debounce of the held enable.
    do_reset(2'd1);
    sw_en = 1'b1;
    wait_active("rr_latency", Latency);
    push_preamble();
    push_run(1, 8);
    run_bits("rr_before", 16);
    rst = 1'b1;
    tick();
    check_eq("rr_data", tx_data, 1'b0);
    check_eq("rr_active", tx_active, 1'b0);
    rst = 1'b0;
    wait_active("rr_restart", Latency);
    push_preamble();
    push_run(1, 8);
    run_bits("rr_after", 16);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/diff_out_pattern_gen.md
DIFF_OUT_PATTERN_GEN -- requirements
Module: diff_out_pattern_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100, meaning clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable cycles before a switch change is accepted (legal range 2..2^24-1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port sw_en, input, 1 bit: raw board switch that enables transmission; asynchronous to clk and bouncy.
REQ-006 SHALL have port sw_mode, input, 2 bits: raw board switches that select the pattern; asynchronous to clk and bouncy.
REQ-007 SHALL have port tx_data, output, 1 bit: registered serial bit that directly drives the I input of a differential output buffer.
REQ-008 SHALL have port tx_active, output, 1 bit: registered flag, high when the FSM is in PREAMBLE or RUN.

Function
REQ-009 SHALL pass each raw switch through a 2-flop synchronizer, then a debouncer.
REQ-010 SHALL update a debounced bit exactly DEBOUNCE_CYCLES cycles after its synchronized input last changed; shorter pulses are discarded.
REQ-011 SHALL run a bit-period counter from 0 to CLK_DIV-1 and assert bit_tick at CLK_DIV-1; the counter is cleared on entry to PREAMBLE.
REQ-012 SHALL implement FSM states IDLE, PREAMBLE and RUN.
REQ-013 SHALL transition IDLE->PREAMBLE when debounced enable is 1.
REQ-014 SHALL transition PREAMBLE->RUN after 8 bit periods.
REQ-015 SHALL transition from any state to IDLE when debounced enable is 0.
REQ-016 SHALL transition RUN->PREAMBLE when the debounced mode changes; the new mode is latched at that point.
REQ-017 SHALL in PREAMBLE transmit 8'b1010_1010 MSB first, each bit held CLK_DIV cycles; the first bit appears on tx_data 1 cycle after entry to PREAMBLE.
REQ-018 SHALL in RUN, mode 0, hold tx_data at 1.
REQ-019 SHALL in RUN, mode 1, alternate 1,0,1,0... starting with 1.
REQ-020 SHALL in RUN, mode 2, output a PRBS7 sequence: lfsr seeded 7'h7F on PREAMBLE entry; output lfsr[6]; next = {lfsr[5:0], lfsr[6]^lfsr[5]}; period 127.
REQ-021 SHALL in RUN, mode 3, serialize an 8-bit counter MSB first; the counter starts at 0, increments after each byte and wraps 255->0.
REQ-022 SHALL advance pattern state only on bit_tick.
REQ-023 SHALL in IDLE drive tx_data=0 and tx_active=0 from the cycle after entry.
REQ-024 SHALL let an enable drop mid-bit abort immediately on the debounced edge, with no completion of the current bit.

Reset
REQ-025 SHALL on rst=1 set the FSM to IDLE, tx_data=0, tx_active=0, all counters to 0, debounced values to 0 and lfsr to 7'h7F, effective the next cycle.
REQ-026 SHALL treat rst asserted mid-RUN like reset and require a full debounce of sw_en before restarting.

Configuration
REQ-027 SHALL when macro DIFF_PATGEN_PRBS_EN is defined, include the LFSR and make mode 2 behave as PRBS7.
REQ-028 SHALL when DIFF_PATGEN_PRBS_EN is undefined, omit the LFSR and make mode 2 behave identically to mode 1.

Structure
REQ-029 SHALL place the mode enum (MODE_HIGH, MODE_TOGGLE, MODE_PRBS, MODE_COUNT), the state enum, PREAMBLE=8'hAA and PRBS_SEED=7'h7F in package diff_patgen_pkg.
REQ-030 SHALL implement the synchronizer and debouncer as sub-module sw_debounce (parameter WIDTH), instantiated once with WIDTH=3.

Verification (CLK_DIV=4, DEBOUNCE_CYCLES=8)
REQ-031 SHALL cover: rst, then sw_en=1 and sw_mode=1 held -> tx_active rises once, followed by 1010_1010 at 4 cycles/bit, then 1,0,1,0 continuing.
REQ-032 SHALL cover: mode 2 with the macro defined -> after the preamble the first 8 bits are 1111_1110 and the sequence repeats after 127 bits; with the macro undefined the same stimulus gives 1,0,1,0.
REQ-033 SHALL cover: mode 3 -> after the preamble, bytes 8'h00, 8'h01, 8'h02 MSB first; after 256 bytes the byte 8'h00 recurs.
REQ-034 SHALL cover: a 5-cycle glitch on sw_en while in IDLE -> tx_active stays 0.
REQ-035 SHALL cover: sw_mode changed 1->0 in RUN -> tx_data returns to 1010_1010 after the debounce, then holds 1.
REQ-036 SHALL cover: rst pulsed mid-RUN -> tx_data=0 and tx_active=0 on the next cycle, and transmission restarts only after 8 cycles of stable enable.
